// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: output mode enum and
// the occupancy/pointer width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_FWFT     = 1'b0,
    FIFO_READ_REQ = 1'b1
  } fifo_mode_e;

  // Pointers and count carry one extra bit so that 0..N and full/empty are distinct.
  function automatic int fifo_cnt_w(input int m);
    return m + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port RAM, one write port and one registered read port.
// The storage array has no reset; only the read register is cleared.
module fifo_mem_sdp #(
  parameter int Nb = 8,
  parameter int M  = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [M-1:0]  i_wr_addr,
  input  logic [Nb-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [M-1:0]  i_rd_addr,
  output logic [Nb-1:0] o_rd_data
);

  logic [Nb-1:0] r_mem [0:(1<<M)-1];
  logic [Nb-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The read register doubles as the FIFO output data register and holds when not enabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_data <= {Nb{1'b0}};
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_wm.sv
// Single-clock FIFO with optional first-word-fall-through output register,
// almost-full/empty thresholds, flush, sticky over/underflow and occupancy watermark.
module fifo_sync_wm
  import fifo_pkg::*;
#(
  parameter int Nb        = 8,
  parameter int M         = 4,
  parameter int FWFT      = 1,
  parameter int AF_THRESH = (1 << M) - 2,
  parameter int AE_THRESH = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_clear_stats,
  input  logic [Nb-1:0] i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic [Nb-1:0] o_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [M:0]    o_count,
  output logic          o_almost_full,
  output logic          o_almost_empty,
  output logic          o_overflow,
  output logic          o_underflow,
  output logic [M:0]    o_watermark
);

  localparam int             CW   = fifo_cnt_w(M);
  localparam int             N    = 1 << M;
  localparam logic [CW-1:0]  N_C  = CW'(N);
  localparam logic [CW-1:0]  AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0]  AE_C = CW'(AE_THRESH);
  localparam fifo_mode_e     MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_READ_REQ;
  localparam logic [CW-1:0]  ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] r_wptr;
  logic [CW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_out_valid;
  logic          r_overflow;
  logic          r_underflow;
  logic [CW-1:0] r_watermark;

  logic          w_in_ready;
  logic          w_wr;
  logic          w_mem_nempty;
  logic          w_rd_xfer;
  logic          w_load;
  logic          w_out_valid_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_ovf_evt;
  logic          w_unf_evt;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;
  logic [CW-1:0] w_wm_nxt;
  logic [Nb-1:0] w_rd_data;

  fifo_mem_sdp #(
    .Nb (Nb),
    .M  (M)
  ) u_mem (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wptr[M-1:0]),
    .i_wr_data (i_in_data),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rptr[M-1:0]),
    .o_rd_data (w_rd_data)
  );

  // Transfer decisions; ready comes from registered count only, so a full FIFO refuses even when read.
  always_comb begin
    w_in_ready      = (r_count != N_C);
    w_wr            = i_in_valid && w_in_ready && !i_flush;
    w_mem_nempty    = (r_wptr != r_rptr);
    w_rd_xfer       = 1'b0;
    w_load          = 1'b0;
    w_out_valid_nxt = r_out_valid;
    w_unf_evt       = 1'b0;
    case (MODE)
      FIFO_FWFT: begin
        w_rd_xfer = r_out_valid && i_out_ready;
        w_load    = (!r_out_valid || w_rd_xfer) && w_mem_nempty;
        if (w_load) begin
          w_out_valid_nxt = 1'b1;
        end else if (w_rd_xfer) begin
          w_out_valid_nxt = 1'b0;
        end else begin
          w_out_valid_nxt = r_out_valid;
        end
      end
      FIFO_READ_REQ: begin
        w_rd_xfer = i_out_ready && (r_count != {CW{1'b0}});
        w_load    = w_rd_xfer;
        w_unf_evt = i_out_ready && (r_count == {CW{1'b0}});
        if (i_out_ready) begin
          w_out_valid_nxt = w_rd_xfer;
        end else begin
          w_out_valid_nxt = r_out_valid;
        end
      end
      default: begin
        w_rd_xfer       = 1'b0;
        w_load          = 1'b0;
        w_out_valid_nxt = r_out_valid;
      end
    endcase
    if (i_flush) begin
      w_rd_xfer       = 1'b0;
      w_load          = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_count_nxt     = {CW{1'b0}};
    end else begin
      w_count_nxt = r_count + (w_wr ? ONE : {CW{1'b0}}) - (w_rd_xfer ? ONE : {CW{1'b0}});
    end
  end

  // Statistics: a same-cycle event beats clear_stats; flush leaves them alone.
  always_comb begin
    w_ovf_evt = i_in_valid && !w_in_ready;
    if (w_ovf_evt) begin
      w_ovf_nxt = 1'b1;
    end else if (i_clear_stats) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_overflow;
    end
    if (w_unf_evt) begin
      w_unf_nxt = 1'b1;
    end else if (i_clear_stats) begin
      w_unf_nxt = 1'b0;
    end else begin
      w_unf_nxt = r_underflow;
    end
    if (i_clear_stats || (w_count_nxt > r_watermark)) begin
      w_wm_nxt = w_count_nxt;
    end else begin
      w_wm_nxt = r_watermark;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wptr      <= {CW{1'b0}};
      r_rptr      <= {CW{1'b0}};
      r_count     <= {CW{1'b0}};
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_watermark <= {CW{1'b0}};
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overflow  <= w_ovf_nxt;
      r_underflow <= w_unf_nxt;
      r_watermark <= w_wm_nxt;
      if (i_flush) begin
        r_wptr <= {CW{1'b0}};
        r_rptr <= {CW{1'b0}};
      end else begin
        if (w_wr) begin
          r_wptr <= r_wptr + ONE;
        end
        if (w_load) begin
          r_rptr <= r_rptr + ONE;
        end
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_out_data     = w_rd_data;
  assign o_out_valid    = r_out_valid;
  assign o_count        = r_count;
  assign o_almost_full  = (r_count >= AF_C);
  assign o_almost_empty = (r_count <= AE_C);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_watermark    = r_watermark;

endmodule
